// File: rtl/jbr_pkg.sv
// Shared decode constants, status codes and FSM encoding for the jump/branch
// status generator.
//   Instruction fields: op [31:26], fields [25:6], funct [5:0].
//   Status codes drive the PC selector as {status2,status1,status0}.
package jbr_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned FN_W    = 6;
    localparam int unsigned CODE_W  = 3;
    localparam int unsigned REG_W   = 5;

    // Opcodes
    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_BZ    = 6'h18;
    localparam logic [OP_W-1:0] OP_JALM  = 6'h13;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;

    // R-type functs: jump/branch group
    localparam logic [FN_W-1:0] FN_BMN   = 6'h14;
    localparam logic [FN_W-1:0] FN_JMOR  = 6'h15;
    localparam logic [FN_W-1:0] FN_BRZ   = 6'h16;
    localparam logic [FN_W-1:0] FN_JSPAL = 6'h17;

    // R-type functs: flag-updating ALU group
    localparam logic [FN_W-1:0] FN_ADD   = 6'h20;
    localparam logic [FN_W-1:0] FN_ADDU  = 6'h21;
    localparam logic [FN_W-1:0] FN_SUB   = 6'h22;
    localparam logic [FN_W-1:0] FN_SUBU  = 6'h23;
    localparam logic [FN_W-1:0] FN_AND   = 6'h24;
    localparam logic [FN_W-1:0] FN_OR    = 6'h25;
    localparam logic [FN_W-1:0] FN_NOR   = 6'h27;
    localparam logic [FN_W-1:0] FN_SLT   = 6'h2A;

    // Branch status codes
    localparam logic [CODE_W-1:0] ST_NONE  = 3'b000;
    localparam logic [CODE_W-1:0] ST_BMN   = 3'b001;
    localparam logic [CODE_W-1:0] ST_BRZ   = 3'b010;
    localparam logic [CODE_W-1:0] ST_BZ    = 3'b011;
    localparam logic [CODE_W-1:0] ST_JMOR  = 3'b100;
    localparam logic [CODE_W-1:0] ST_JALM  = 3'b101;
    localparam logic [CODE_W-1:0] ST_JSPAL = 3'b110;

    typedef struct packed {
        logic [OP_W-1:0]             op;
        logic [INSTR_W-OP_W-FN_W-1:0] fields;
        logic [FN_W-1:0]             funct;
    } instr_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_JSPAL = 1'b1
    } jbr_state_e;

endpackage

// File: rtl/jbr_flag_reg.sv
// N/Z/V condition flag register.
//   clk, rst      : clock, async active-high reset (flags clear to 0)
//   op_i, funct_i : decoded opcode/funct of the retiring instruction
//   alu_result_i  : ALU result, alu_ovf_i: signed overflow
//   stall_i       : no flag update while the PC is held
//   n_o, z_o, v_o : registered flags
module jbr_flag_reg
    import jbr_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned FLAG_ON_IMM = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OP_W-1:0]   op_i,
    input  logic [FN_W-1:0]   funct_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_ovf_i,
    input  logic              stall_i,
    output logic              n_o,
    output logic              z_o,
    output logic              v_o
);

    logic upd_c;
    logic n_q, z_q, v_q;

    // Update-class decode: R-type ALU ops, optionally the I-type ALU ops
    always_comb begin
        upd_c = 1'b0;
        if (op_i == OP_RTYPE) begin
            case (funct_i)
                FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                FN_AND, FN_OR, FN_NOR, FN_SLT: upd_c = 1'b1;
                default:                       upd_c = 1'b0;
            endcase
        end else if (FLAG_ON_IMM != 0) begin
            case (op_i)
                OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: upd_c = 1'b1;
                default:                           upd_c = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q <= 1'b0;
            z_q <= 1'b0;
            v_q <= 1'b0;
        end else if (upd_c && !stall_i) begin
            n_q <= alu_result_i[DATA_W-1];
            z_q <= (alu_result_i == '0);
            v_q <= alu_ovf_i;
        end
    end

    assign n_o = n_q;
    assign z_o = z_q;
    assign v_o = v_q;

endmodule

// File: rtl/jbr_status_gen.sv
// Jump/branch status generator: branch status code, N/Z/V flags, jalm link
// request and the two-cycle jspal sequence.
//   clk, reset        : clock, async active-high reset
//   instr             : current instruction word
//   alu_result/ovf    : ALU result and signed overflow
//   mem_out           : data-memory read data
//   status0..2        : branch status code to the PC selector
//   n, z, v           : registered flags
//   jbr_mem_out       : jump target data to the PC selector
//   stall             : hold PC and register-file write
//   mem_wr_link       : write pc4 to mem[$sp]
//   mem_addr_sp       : force data-memory address to $sp
//   link_we/link_addr : register-file write of pc4
module jbr_status_gen
    import jbr_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned LINK_REG    = 31,
    parameter int unsigned FLAG_ON_IMM = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               alu_ovf,
    input  logic [DATA_W-1:0]  mem_out,
    output logic               status0,
    output logic               status1,
    output logic               status2,
    output logic               n,
    output logic               z,
    output logic               v,
    output logic [DATA_W-1:0]  jbr_mem_out,
    output logic               stall,
    output logic               mem_wr_link,
    output logic               mem_addr_sp,
    output logic               link_we,
    output logic [REG_W-1:0]   link_addr
);

    instr_t            ins_c;
    logic              fields_unused;
    logic              is_jspal_c;
    logic [CODE_W-1:0] dec_code_c;
    logic [CODE_W-1:0] code_c;

    jbr_state_e        state_q, state_d;
    logic [DATA_W-1:0] tgt_q, tgt_d;

    assign ins_c         = instr_t'(instr);
    assign fields_unused = ^ins_c.fields;
    assign is_jspal_c    = (ins_c.op == OP_RTYPE) && (ins_c.funct == FN_JSPAL);

    // Static decode; jspal only reports its code in its second cycle
    always_comb begin
        dec_code_c = ST_NONE;
        if (ins_c.op == OP_RTYPE) begin
            case (ins_c.funct)
                FN_BMN:  dec_code_c = ST_BMN;
                FN_BRZ:  dec_code_c = ST_BRZ;
                FN_JMOR: dec_code_c = ST_JMOR;
                default: dec_code_c = ST_NONE;
            endcase
        end else if (ins_c.op == OP_BZ) begin
            dec_code_c = ST_BZ;
        end else if (ins_c.op == OP_JALM) begin
            dec_code_c = ST_JALM;
        end
    end

    // jspal sequencing and output decode; a jspal is not started while reset
    // is held so the PC selector sees plain decode during reset
    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        code_c      = dec_code_c;
        stall       = 1'b0;
        mem_addr_sp = 1'b0;
        mem_wr_link = 1'b0;
        link_we     = (dec_code_c == ST_JALM);
        jbr_mem_out = mem_out;
        case (state_q)
            S_IDLE: begin
                if (is_jspal_c && !reset) begin
                    stall       = 1'b1;
                    mem_addr_sp = 1'b1;
                    code_c      = ST_NONE;
                    link_we     = 1'b0;
                    tgt_d       = mem_out;
                    state_d     = S_JSPAL;
                end
            end
            S_JSPAL: begin
                mem_addr_sp = 1'b1;
                mem_wr_link = 1'b1;
                code_c      = ST_JSPAL;
                link_we     = 1'b0;
                jbr_mem_out = tgt_q;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
        end
    end

    jbr_flag_reg #(
        .DATA_W      (DATA_W),
        .FLAG_ON_IMM (FLAG_ON_IMM)
    ) u_flag_reg (
        .clk          (clk),
        .rst          (reset),
        .op_i         (ins_c.op),
        .funct_i      (ins_c.funct),
        .alu_result_i (alu_result),
        .alu_ovf_i    (alu_ovf),
        .stall_i      (stall),
        .n_o          (n),
        .z_o          (z),
        .v_o          (v)
    );

    assign {status2, status1, status0} = code_c;
    assign link_addr                   = REG_W'(LINK_REG);

endmodule

// File: tb/tb_jbr_status_gen.sv
// Bench for jbr_status_gen: directed table, jspal/reset sequences and random
// stimulus against an instruction-level model. A second instance is built
// with immediate ops excluded from flag updates.
module tb_jbr_status_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic [31:0] alu_result;
    logic        alu_ovf;
    logic [31:0] mem_out;

    logic        a_s0, a_s1, a_s2, a_n, a_z, a_v, a_stall, a_wr, a_sp, a_lwe;
    logic [31:0] a_jbr;
    logic [4:0]  a_la;
    logic        b_s0, b_s1, b_s2, b_n, b_z, b_v, b_stall, b_wr, b_sp, b_lwe;
    logic [31:0] b_jbr;
    logic [4:0]  b_la;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: architectural flags per build, jspal phase, latched target
    bit          mn, mz, mv;
    bit          bn, bz, bv;
    int          phase;
    logic [31:0] mtgt;

    always #5 clk = ~clk;

    jbr_status_gen #(.DATA_W(32), .LINK_REG(31), .FLAG_ON_IMM(1)) dut (
        .clk(clk), .reset(reset), .instr(instr), .alu_result(alu_result),
        .alu_ovf(alu_ovf), .mem_out(mem_out),
        .status0(a_s0), .status1(a_s1), .status2(a_s2),
        .n(a_n), .z(a_z), .v(a_v), .jbr_mem_out(a_jbr), .stall(a_stall),
        .mem_wr_link(a_wr), .mem_addr_sp(a_sp), .link_we(a_lwe), .link_addr(a_la)
    );

    jbr_status_gen #(.DATA_W(32), .LINK_REG(31), .FLAG_ON_IMM(0)) dut_noimm (
        .clk(clk), .reset(reset), .instr(instr), .alu_result(alu_result),
        .alu_ovf(alu_ovf), .mem_out(mem_out),
        .status0(b_s0), .status1(b_s1), .status2(b_s2),
        .n(b_n), .z(b_z), .v(b_v), .jbr_mem_out(b_jbr), .stall(b_stall),
        .mem_wr_link(b_wr), .mem_addr_sp(b_sp), .link_we(b_lwe), .link_addr(b_la)
    );

    function automatic logic [31:0] r_ins(input logic [5:0] fn);
        return {6'h00, 5'd8, 5'd9, 5'd10, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op);
        return {op, 5'd8, 5'd9, 16'h0010};
    endfunction

    function automatic bit m_is_jspal(input logic [31:0] ins);
        return (ins[31:26] == 6'h00) && (ins[5:0] == 6'h17);
    endfunction

    // Status code the PC selector should see for an instruction in idle
    function automatic logic [2:0] m_code(input logic [31:0] ins);
        logic [5:0] op;
        logic [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        if (op == 6'h13) return 3'd5;
        if (op == 6'h18) return 3'd3;
        if (op != 6'h00) return 3'd0;
        if (fn == 6'h14) return 3'd1;
        if (fn == 6'h16) return 3'd2;
        if (fn == 6'h15) return 3'd4;
        return 3'd0;
    endfunction

    function automatic bit m_upd(input logic [31:0] ins, input bit imm);
        logic [5:0] op;
        logic [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        if (op == 6'h00)
            return fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A};
        return imm && (op inside {6'h08, 6'h0A, 6'h0C, 6'h0D});
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare every output of both builds with the model
    task automatic check_all();
        logic [2:0]  ecode;
        logic        estall, esp, ewr, elwe;
        logic [31:0] ejbr;
        if (phase == 1) begin
            ecode = 3'd6; estall = 1'b0; esp = 1'b1; ewr = 1'b1; elwe = 1'b0; ejbr = mtgt;
        end else if (m_is_jspal(instr)) begin
            ecode = 3'd0; estall = 1'b1; esp = 1'b1; ewr = 1'b0; elwe = 1'b0; ejbr = mem_out;
        end else begin
            ecode = m_code(instr); estall = 1'b0; esp = 1'b0; ewr = 1'b0;
            elwe = (ecode == 3'd5); ejbr = mem_out;
        end
        chk("code",   32'({a_s2, a_s1, a_s0}), 32'(ecode));
        chk("stall",  32'(a_stall), 32'(estall));
        chk("sp",     32'(a_sp), 32'(esp));
        chk("wr",     32'(a_wr), 32'(ewr));
        chk("lwe",    32'(a_lwe), 32'(elwe));
        chk("jbr",    a_jbr, ejbr);
        chk("nzv",    32'({a_n, a_z, a_v}), 32'({mn, mz, mv}));
        chk("b_code", 32'({b_s2, b_s1, b_s0}), 32'(ecode));
        chk("b_stall", 32'(b_stall), 32'(estall));
        chk("b_wr",   32'(b_wr), 32'(ewr));
        chk("b_nzv",  32'({b_n, b_z, b_v}), 32'({bn, bz, bv}));
        if (elwe) begin
            chk("link_addr", 32'(a_la), 32'd31);
            chk("b_link_addr", 32'(b_la), 32'd31);
        end
    endtask

    task automatic apply(input logic [31:0] ins, input logic [31:0] alu,
                         input logic ovf, input logic [31:0] mem);
        @(negedge clk);
        instr = ins; alu_result = alu; alu_ovf = ovf; mem_out = mem;
        #1;
        check_all();
    endtask

    // Advance the model across one rising edge
    task automatic clk_edge();
        bit st;
        @(posedge clk);
        st = (phase == 0) && m_is_jspal(instr);
        if (!st) begin
            if (m_upd(instr, 1'b1)) {mn, mz, mv} = {alu_result[31], alu_result == 32'h0, alu_ovf};
            if (m_upd(instr, 1'b0)) {bn, bz, bv} = {alu_result[31], alu_result == 32'h0, alu_ovf};
        end
        if (phase == 1) phase = 0;
        else if (st) begin
            phase = 1;
            mtgt  = mem_out;
        end
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [31:0] alu;
        logic        ovf;
        logic [2:0]  code;
        logic [2:0]  nzv;
    } vec_t;

    vec_t        tbl[$];
    logic [5:0]  rfn[8] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A};
    logic [5:0]  iop[4] = '{6'h08, 6'h0A, 6'h0C, 6'h0D};

    function automatic logic [31:0] rand_ins();
        int k;
        k = $urandom_range(0, 19);
        if (k < 8)   return {6'h00, 20'($urandom), rfn[k]};
        if (k < 12)  return {iop[k-8], 26'($urandom)};
        case (k)
            12: return r_ins(6'h14);
            13: return r_ins(6'h16);
            14: return r_ins(6'h15);
            15: return r_ins(6'h17);
            16: return i_ins(6'h18);
            17: return i_ins(6'h13);
            18: return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] ri;
        reset = 1'b1; instr = 32'h0; alu_result = 32'h0; alu_ovf = 1'b0; mem_out = 32'h0;
        mn = 0; mz = 0; mv = 0; bn = 0; bz = 0; bv = 0; phase = 0; mtgt = 32'h0;

        // Reset state: flags clear, decode follows instr
        #3;
        chk("rst_nzv", 32'({a_n, a_z, a_v}), 32'h0);
        chk("rst_stall", 32'(a_stall), 32'h0);
        instr = r_ins(6'h14);
        #1;
        chk("rst_code_bmn", 32'({a_s2, a_s1, a_s0}), 32'd1);
        @(negedge clk);
        reset = 1'b0;

        // Directed table: flags shown are those visible during the vector
        tbl.push_back('{i_ins(6'h08), 32'hFFFF_FFF0, 1'b0, 3'd0, 3'b000});
        tbl.push_back('{r_ins(6'h14), 32'h0000_0001, 1'b0, 3'd1, 3'b100});
        tbl.push_back('{r_ins(6'h22), 32'h0000_0000, 1'b0, 3'd0, 3'b100});
        tbl.push_back('{r_ins(6'h16), 32'h0000_0007, 1'b0, 3'd2, 3'b010});
        tbl.push_back('{i_ins(6'h18), 32'h8000_0000, 1'b1, 3'd3, 3'b010});
        tbl.push_back('{r_ins(6'h20), 32'h0000_0005, 1'b1, 3'd0, 3'b010});
        tbl.push_back('{32'h0,        32'h0000_0000, 1'b0, 3'd0, 3'b001});
        tbl.push_back('{32'h0,        32'h8000_0000, 1'b0, 3'd0, 3'b001});
        tbl.push_back('{r_ins(6'h15), 32'h0000_0000, 1'b0, 3'd4, 3'b001});
        tbl.push_back('{i_ins(6'h13), 32'h0000_0000, 1'b0, 3'd5, 3'b001});
        tbl.push_back('{32'h0,        32'h0000_0000, 1'b0, 3'd0, 3'b001});
        tbl.push_back('{i_ins(6'h08), 32'h0000_0000, 1'b0, 3'd0, 3'b001});
        tbl.push_back('{32'h0,        32'h0000_0000, 1'b0, 3'd0, 3'b010});
        foreach (tbl[i]) begin
            apply(tbl[i].ins, tbl[i].alu, tbl[i].ovf, 32'h1000_0000 + 32'(i));
            chk($sformatf("tbl%0d_code", i), 32'({a_s2, a_s1, a_s0}), 32'(tbl[i].code));
            chk($sformatf("tbl%0d_nzv", i), 32'({a_n, a_z, a_v}), 32'(tbl[i].nzv));
            clk_edge();
        end
        chk("noimm_z_held", 32'(b_z), 32'h0);
        chk("noimm_v_held", 32'(b_v), 32'h1);

        // jspal: hold cycle, then target from the first cycle's mem_out
        apply(r_ins(6'h17), 32'h0, 1'b0, 32'h0040_0040);
        chk("js1_stall", 32'(a_stall), 32'h1);
        chk("js1_code", 32'({a_s2, a_s1, a_s0}), 32'd0);
        chk("js1_sp", 32'(a_sp), 32'h1);
        clk_edge();
        apply(r_ins(6'h17), 32'h0, 1'b0, 32'hDEAD_BEEF);
        chk("js2_code", 32'({a_s2, a_s1, a_s0}), 32'd6);
        chk("js2_jbr", a_jbr, 32'h0040_0040);
        chk("js2_wr", 32'(a_wr), 32'h1);
        chk("js2_stall", 32'(a_stall), 32'h0);
        clk_edge();
        apply(32'h0, 32'h0, 1'b0, 32'h1234_5678);
        chk("js3_stall", 32'(a_stall), 32'h0);
        chk("js3_jbr", a_jbr, 32'h1234_5678);
        chk("js3_wr", 32'(a_wr), 32'h0);
        clk_edge();

        // Reset asserted while in the jspal second cycle
        apply(r_ins(6'h20), 32'h8000_0000, 1'b1, 32'h0);
        clk_edge();
        apply(r_ins(6'h17), 32'h0, 1'b0, 32'hCAFE_0000);
        clk_edge();
        @(negedge clk);
        instr = r_ins(6'h17); mem_out = 32'hAAAA_5555;
        #1;
        chk("mid_code", 32'({a_s2, a_s1, a_s0}), 32'd6);
        chk("mid_wr", 32'(a_wr), 32'h1);
        chk("mid_nzv", 32'({a_n, a_z, a_v}), 32'b101);
        #1 reset = 1'b1;
        #1;
        chk("abort_wr", 32'(a_wr), 32'h0);
        chk("abort_sp", 32'(a_sp), 32'h0);
        chk("abort_stall", 32'(a_stall), 32'h0);
        chk("abort_code", 32'({a_s2, a_s1, a_s0}), 32'd0);
        chk("abort_jbr", a_jbr, 32'hAAAA_5555);
        chk("abort_nzv", 32'({a_n, a_z, a_v}), 32'h0);
        chk("abort_b_nzv", 32'({b_n, b_z, b_v}), 32'h0);
        instr = r_ins(6'h15);
        #1;
        chk("abort_follow", 32'({a_s2, a_s1, a_s0}), 32'd4);
        mn = 0; mz = 0; mv = 0; bn = 0; bz = 0; bv = 0; phase = 0; mtgt = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        apply(32'h0, 32'h0, 1'b0, 32'h5555_0000);
        clk_edge();

        // Random stimulus; the PC holds during jspal so the word repeats
        for (int c = 0; c < 400; c++) begin
            ri = (phase == 1) ? r_ins(6'h17) : rand_ins();
            apply(ri, ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom,
                  1'($urandom_range(0, 1)), $urandom);
            clk_edge();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
